// File: rtl/alu_op_arbiter_pkg.sv
// alu_pkg: unit codes, FSM states and a sizing helper shared by the ALU operation arbiter
package alu_pkg;
    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/alu_op_arbiter_grant_sel.sv
// alu_grant_sel: combinational one-hot grant and index over the request vector
// ALU_ARB_RR_EN defined: search starts at ptr (round-robin); undefined: lowest index wins.
module alu_grant_sel
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               hit
);
    logic [NUM_REQ-1:0] rot;
    logic [IW-1:0]      base;
    logic [IW-1:0]      k;
    logic [IW:0]        sum;

`ifdef ALU_ARB_RR_EN
    logic [2*NUM_REQ-1:0] dbl;
    // rotate so the requester at ptr sits at bit 0
    assign dbl  = {req, req} >> ptr;
    assign rot  = dbl[NUM_REQ-1:0];
    assign base = ptr;
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign rot  = req;
    assign base = '0;
`endif

    assign hit = |req;

    always_comb begin
        k = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) k = IW'(i);
        sum   = {1'b0, base} + {1'b0, k};
        idx   = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : IW'(sum);
        grant = hit ? NUM_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter: shares one registered-output ALU among NUM_REQ requesters, one op in flight
// Define ALU_ARB_RR_EN for round-robin grant; otherwise fixed priority, lowest index first.
module alu_op_arbiter
    import alu_pkg::*;
#(
    parameter int ALU_WIDTH = 16,
    parameter int NUM_REQ   = 4,
    parameter int ALU_LAT   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ALU_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*ALU_WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*4-1:0]           req_fun,
    output logic                           arith_enable,
    output logic                           logic_enable,
    output logic                           cmp_enable,
    output logic                           shift_enable,
    output logic [1:0]                     alu_fun,
    output logic [ALU_WIDTH-1:0]           alu_a,
    output logic [ALU_WIDTH-1:0]           alu_b,
    input  logic [ALU_WIDTH-1:0]           alu_out,
    input  logic                           alu_flag,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
    output logic [ALU_WIDTH-1:0]           rsp_data,
    output logic                           rsp_flag,
    output logic                           busy
);
    localparam int IW = clog2_min1(NUM_REQ);
    localparam int CW = clog2_min1(ALU_LAT + 1);

    state_t               state, state_nxt;
    logic [NUM_REQ-1:0]   grant;
    logic [IW-1:0]        gidx, ptr, op_id;
    logic                 hit, accept;
    logic [ALU_WIDTH-1:0] op_a, op_b;
    logic [3:0]           op_fun;
    logic [CW-1:0]        cnt;

    alu_grant_sel #(.NUM_REQ(NUM_REQ), .IW(IW)) u_grant (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .hit   (hit)
    );

    assign accept = (state == IDLE) && hit;

`ifdef ALU_ARB_RR_EN
    always_ff @(posedge clk or posedge rst)
        if (rst)
            ptr <= '0;
        else if (accept)
            ptr <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == CW'(1)) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            op_fun   <= '0;
            op_id    <= '0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_flag <= 1'b0;
        end else begin
            if (accept) begin
                op_a   <= req_a[gidx*ALU_WIDTH +: ALU_WIDTH];
                op_b   <= req_b[gidx*ALU_WIDTH +: ALU_WIDTH];
                op_fun <= req_fun[gidx*4 +: 4];
                op_id  <= gidx;
            end
            if (state == ISSUE)
                cnt <= CW'(ALU_LAT);
            else if (state == WAIT)
                cnt <= cnt - 1'b1;
            // the unit output is valid only in the last WAIT cycle
            if (state == WAIT && cnt == CW'(1)) begin
                rsp_data <= alu_out;
                rsp_flag <= alu_flag;
            end
        end

    // req_ready is gated by rst so every output reads 0 while reset is held
    always_comb begin
        req_ready    = (state == IDLE && !rst) ? grant : '0;
        arith_enable = (state == ISSUE) && (op_fun[3:2] == UNIT_ARITH);
        logic_enable = (state == ISSUE) && (op_fun[3:2] == UNIT_LOGIC);
        cmp_enable   = (state == ISSUE) && (op_fun[3:2] == UNIT_CMP);
        shift_enable = (state == ISSUE) && (op_fun[3:2] == UNIT_SHIFT);
        alu_fun      = (state == ISSUE) ? op_fun[1:0] : 2'b00;
        alu_a        = (state == ISSUE) ? op_a : '0;
        alu_b        = (state == ISSUE) ? op_b : '0;
        rsp_valid    = (state == RESP);
        busy         = (state != IDLE);
    end

    assign rsp_id = op_id;
endmodule

// File: tb/tb_alu_op_arbiter.sv
// tb_alu_op_arbiter: directed and randomized checks of alu_op_arbiter against a cycle-level reference model
module tb_alu_op_arbiter;
    localparam int W   = 16;
    localparam int N   = 4;
    localparam int LAT = 3;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [N*4-1:0] req_fun;
    logic           arith_enable, logic_enable, cmp_enable, shift_enable;
    logic [1:0]     alu_fun;
    logic [W-1:0]   alu_a, alu_b, alu_out, rsp_data;
    logic           alu_flag, rsp_valid, rsp_ready, rsp_flag, busy;
    logic [1:0]     rsp_id;

    logic [N-1:0]   s_req_valid, s_req_ready;
    logic [N*W-1:0] s_req_a, s_req_b;
    logic [N*4-1:0] s_req_fun;
    logic           s_arith_enable, s_logic_enable, s_cmp_enable, s_shift_enable;
    logic [1:0]     s_alu_fun;
    logic [W-1:0]   s_alu_a, s_alu_b, s_rsp_data;
    logic [W-1:0]   s_alu_out = '0;
    logic           s_alu_flag = 1'b0;
    logic           s_rsp_valid, s_rsp_ready, s_rsp_flag, s_busy;
    logic [1:0]     s_rsp_id;

    alu_op_arbiter #(.ALU_WIDTH(W), .NUM_REQ(N), .ALU_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
        .arith_enable(arith_enable), .logic_enable(logic_enable),
        .cmp_enable(cmp_enable), .shift_enable(shift_enable),
        .alu_fun(alu_fun), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag), .busy(busy)
    );

    alu_op_arbiter #(.ALU_WIDTH(W), .NUM_REQ(N), .ALU_LAT(1)) u_dut_lat1 (
        .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_a(s_req_a), .req_b(s_req_b), .req_fun(s_req_fun),
        .arith_enable(s_arith_enable), .logic_enable(s_logic_enable),
        .cmp_enable(s_cmp_enable), .shift_enable(s_shift_enable),
        .alu_fun(s_alu_fun), .alu_a(s_alu_a), .alu_b(s_alu_b),
        .alu_out(s_alu_out), .alu_flag(s_alu_flag),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id),
        .rsp_data(s_rsp_data), .rsp_flag(s_rsp_flag), .busy(s_busy)
    );

    function automatic logic [W-1:0] alu_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
        return (a - b) ^ {4{f}};
    endfunction

    function automatic logic flag_of(input logic [W-1:0] d);
        return d[0] ^ d[W-1];
    endfunction

    // ALU environment: result appears LAT cycles after the enable pulse, zero otherwise
    logic [LAT-1:0] pv = '0;
    logic [W-1:0]   pd [LAT];
    logic [1:0]     unit_code, s_code;
    logic           s_en;
    assign unit_code = {shift_enable | cmp_enable, shift_enable | logic_enable};
    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], arith_enable | logic_enable | cmp_enable | shift_enable};
        pd[0] <= alu_res(alu_a, alu_b, {unit_code, alu_fun});
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
    assign alu_out  = pv[LAT-1] ? pd[LAT-1] : '0;
    assign alu_flag = pv[LAT-1] & flag_of(pd[LAT-1]);

    assign s_code = {s_shift_enable | s_cmp_enable, s_shift_enable | s_logic_enable};
    assign s_en   = s_arith_enable | s_logic_enable | s_cmp_enable | s_shift_enable;
    always @(posedge clk) begin
        s_alu_out  <= s_en ? alu_res(s_alu_a, s_alu_b, {s_code, s_alu_fun}) : '0;
        s_alu_flag <= s_en & flag_of(alu_res(s_alu_a, s_alu_b, {s_code, s_alu_fun}));
    end

    int checks = 0;
    int failures = 0;

    logic [W-1:0] ra [N];
    logic [W-1:0] rb [N];
    logic [3:0]   rf [N];
    logic [N-1:0] rv;
    bit           cont;

    int           phase, ptr, cur_id, last_g, obs_g, lat;
    logic [W-1:0] cur_a, cur_b, exp_d, last_d;
    logic [3:0]   cur_f;
    logic         exp_f, last_f;
    int           order [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {1'b0, req_ready, arith_enable, logic_enable, cmp_enable, shift_enable, alu_fun,
                alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_flag, busy};
    endfunction

    function automatic logic [63:0] s_outs();
        return {1'b0, s_req_ready, s_arith_enable, s_logic_enable, s_cmp_enable, s_shift_enable, s_alu_fun,
                s_alu_a, s_alu_b, s_rsp_valid, s_rsp_id, s_rsp_data, s_rsp_flag, s_busy};
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W]   = ra[i];
            req_b[i*W +: W]   = rb[i];
            req_fun[i*4 +: 4] = rf[i];
        end
        req_valid = rv;
    endtask

    task automatic new_op(input int i);
        ra[i] = W'($urandom);
        rb[i] = W'($urandom);
        rf[i] = 4'($urandom);
        rv[i] = 1'b1;
    endtask

    // one clock of the reference model: phase 0 idle, 1 issue, 2..LAT+1 wait, >=LAT+2 response
    task automatic tick();
        int g;
        logic [N-1:0] er;
        drive();
        @(negedge clk);
        g  = pick(req_valid, RR ? ptr : 0);
        er = (phase == 0 && g >= 0) ? N'(1) << g : '0;
        obs_g = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) obs_g = i;
        chk("req_ready", req_ready, er);
        chk("busy", busy, phase != 0);
        chk("enables", {shift_enable, cmp_enable, logic_enable, arith_enable}, phase == 1 ? 4'b0001 << cur_f[3:2] : 4'b0000);
        chk("alu_fun", alu_fun, phase == 1 ? cur_f[1:0] : 2'b00);
        chk("alu_a", alu_a, phase == 1 ? cur_a : '0);
        chk("alu_b", alu_b, phase == 1 ? cur_b : '0);
        chk("rsp_valid", rsp_valid, phase >= LAT + 2);
        chk("rsp_data", rsp_data, phase >= LAT + 2 ? exp_d : last_d);
        chk("rsp_flag", rsp_flag, phase >= LAT + 2 ? exp_f : last_f);
        if (phase >= LAT + 2) chk("rsp_id", rsp_id, cur_id);
        last_g = -1;
        if (phase == 0) begin
            if (g >= 0) begin
                cur_id = g;
                cur_a  = ra[g];
                cur_b  = rb[g];
                cur_f  = rf[g];
                exp_d  = alu_res(cur_a, cur_b, cur_f);
                exp_f  = flag_of(exp_d);
                ptr    = (g + 1) % N;
                phase  = 1;
                last_g = g;
            end
        end else if (phase < LAT + 2) begin
            phase++;
        end else if (rsp_ready) begin
            phase  = 0;
            last_d = exp_d;
            last_f = exp_f;
        end
        @(posedge clk);
        #1;
        if (last_g >= 0) begin
            if (cont) new_op(last_g);
            else rv[last_g] = 1'b0;
        end
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while ((phase != 0 || rv != '0) && n < lim) begin
            tick();
            n++;
        end
        chk("drain_in_time", n < lim, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rb[i] = '0;
            rf[i] = '0;
        end
        rv = '0;
        cont = 1'b0;
        phase = 0; ptr = 0; cur_id = 0; last_g = -1; obs_g = -1;
        cur_a = '0; cur_b = '0; cur_f = '0; exp_d = '0; exp_f = 1'b0; last_d = '0; last_f = 1'b0;
        rsp_ready = 1'b0;
        s_req_valid = '0; s_req_a = '0; s_req_b = '0; s_req_fun = '0; s_rsp_ready = 1'b0;
        drive();
        @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 64'h0);
        chk("reset_outputs_lat1", s_outs(), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // logic op on the ALU_LAT=1 instance
        s_rsp_ready = 1'b1;
        s_req_a[W-1:0] = 16'h00F0;
        s_req_b[W-1:0] = 16'h0F00;
        s_req_fun[3:0] = 4'b0100;
        s_req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_ready", s_req_ready, 4'b0001);
        @(posedge clk);
        #1 s_req_valid = '0;
        @(negedge clk);
        chk("t1_enables", {s_shift_enable, s_cmp_enable, s_logic_enable, s_arith_enable}, 4'b0010);
        chk("t1_alu_fun", s_alu_fun, 2'b00);
        chk("t1_alu_a", s_alu_a, 16'h00F0);
        chk("t1_alu_b", s_alu_b, 16'h0F00);
        @(negedge clk);
        chk("t1_enables_off", {s_shift_enable, s_cmp_enable, s_logic_enable, s_arith_enable}, 4'b0000);
        chk("t1_wait_no_valid", s_rsp_valid, 1'b0);
        @(negedge clk);
        chk("t1_rsp_valid", s_rsp_valid, 1'b1);
        chk("t1_rsp_id", s_rsp_id, 2'd0);
        chk("t1_rsp_data", s_rsp_data, alu_res(16'h00F0, 16'h0F00, 4'b0100));
        chk("t1_rsp_flag", s_rsp_flag, flag_of(alu_res(16'h00F0, 16'h0F00, 4'b0100)));
        @(negedge clk);
        chk("t1_rsp_done", s_rsp_valid, 1'b0);
        chk("t1_idle", s_busy, 1'b0);
        @(posedge clk);
        #1;

        // response back-pressure: held 5 cycles while another request waits
        rsp_ready = 1'b0;
        new_op(1);
        rf[1] = 4'b1100;
        tick();
        new_op(0);
        for (int n = 0; n < 20 && phase < LAT + 2; n++) tick();
        repeat (5) tick();
        rsp_ready = 1'b1;
        drain(60);

        // ALU_LAT=3 latency and data
        new_op(2);
        ra[2] = 16'hBEEF;
        rb[2] = 16'h0000;
        rf[2] = 4'b0000;
        tick();
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("t4_latency", lat, LAT + 2);
        chk("t4_data", rsp_data, 16'hBEEF);
        drain(20);

        // asynchronous reset in the middle of WAIT
        new_op(3);
        tick();
        tick();
        new_op(0);
        drive();
        #2 rst = 1'b1;
        #1 chk("t5_async_zero", outs(), 64'h0);
        phase = 0; ptr = 0; last_d = '0; last_f = 1'b0;
        rv = '0;
        drive();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (8) tick();

        // all requesters valid continuously
        cont = 1'b1;
        for (int i = 0; i < N; i++) new_op(i);
        for (int n = 0; n < 80 && order.size() < 5; n++) begin
            tick();
            if (obs_g >= 0) order.push_back(obs_g);
        end
        chk("t3_grants", order.size(), 5);
        for (int k = 0; k < order.size(); k++)
            chk($sformatf("t3_grant%0d", k), order[k], RR ? k % N : 0);
        cont = 1'b0;
        rv = '0;
        drain(40);

        // each unit code
        for (int u = 0; u < 4; u++) begin
            new_op(2);
            rf[2][3:2] = u[1:0];
            drain(40);
        end

        // randomized traffic with drops and back-pressure
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && $urandom_range(0, 3) == 0) new_op(i);
                else if (rv[i] && $urandom_range(0, 19) == 0) rv[i] = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rsp_ready = 1'b1;
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
